// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift arbiter.
//   shift_type_e : operation encoding on req_type (SLL/SRL/SRA/ROR)
//   arb_state_e  : arbiter FSM state encoding
package shift_arb_pkg;

  typedef enum logic [1:0] {
    ShSll = 2'b00,
    ShSrl = 2'b01,
    ShSra = 2'b10,
    ShRor = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } arb_state_e;

endpackage

// File: rtl/shifter_32.sv
// 32-bit combinational shifter shared by all requesters.
// Ports:
//   a          : operand
//   amt        : shift amount 0..31
//   shift_type : SLL/SRL (zero fill), SRA (sign fill), ROR (rotate right)
//   result     : shifted operand; amt=0 returns a for every type
module shifter_32
  import shift_arb_pkg::*;
(
  input  logic [31:0]  a,
  input  logic [4:0]   amt,
  input  shift_type_e  shift_type,
  output logic [31:0]  result
);

  logic [5:0] ror_back;

  // For amt=0 the left shift is by 32, which yields zero, so ROR returns a.
  assign ror_back = 6'd32 - {1'b0, amt};

  always_comb begin
    result = a;
    unique case (shift_type)
      ShSll:   result = a << amt;
      ShSrl:   result = a >> amt;
      ShSra:   result = $signed(a) >>> amt;
      ShRor:   result = (a >> amt) | (a << ror_back);
      default: result = a;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates NREQ requesters onto one shared 32-bit shifter.
// One operation in flight: IDLE (grant) -> EXEC (shift) -> RESP (hold result).
// Macro SHIFT_ARB_RR_EN selects round-robin arbitration; otherwise fixed
// priority with the lowest index winning.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a/req_amt/req_type: packed per-requester operand, amount, shift type
//   rsp_valid / rsp_ready : result handshake
//   rsp_data, rsp_id      : result and owning requester index
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [5*NREQ-1:0]    req_amt,
  input  logic [2*NREQ-1:0]    req_type,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [IW-1:0]        rsp_id
);

  arb_state_e  state_q, state_d;
  logic [IW-1:0] win_idx;
  logic          accept;
  logic [31:0]   a_q;
  logic [4:0]    amt_q;
  shift_type_e   type_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   shift_out;
  logic [31:0]   rsp_data_q;
  logic [IW-1:0] rsp_id_q;

`ifdef SHIFT_ARB_RR_EN
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] scan_idx;

  function automatic logic [IW-1:0] rr_idx(logic [IW-1:0] base, int unsigned off);
    return IW'((32'(base) + off) % NREQ);
  endfunction

  // Scan farthest-first so the requester nearest after ptr_q is written last.
  always_comb begin
    win_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      scan_idx = rr_idx(ptr_q, k);
      if (req_valid[scan_idx]) win_idx = scan_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (accept) begin
      ptr_q <= win_idx;
    end
  end
`else
  // Highest index first so the lowest valid index is written last.
  always_comb begin
    win_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_valid[k[IW-1:0]]) win_idx = k[IW-1:0];
    end
  end
`endif

  // Reset gates the grant so req_ready drops without waiting for a clock.
  assign accept    = rst_n && (state_q == StIdle) && (|req_valid);
  assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|req_valid) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      a_q        <= '0;
      amt_q      <= '0;
      type_q     <= ShSll;
      idx_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= req_a[32*win_idx +: 32];
        amt_q  <= req_amt[5*win_idx +: 5];
        type_q <= shift_type_e'(req_type[2*win_idx +: 2]);
        idx_q  <= win_idx;
      end
      if (state_q == StExec) begin
        rsp_data_q <= shift_out;
        rsp_id_q   <= idx_q;
      end
    end
  end

  shifter_32 u_shifter (
    .a          (a_q),
    .amt        (amt_q),
    .shift_type (type_q),
    .result     (shift_out)
  );

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter (NREQ=4), directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_shift_arbiter;
  import shift_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [5*NREQ-1:0]    req_amt;
  logic [2*NREQ-1:0]    req_type;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic [IW-1:0]        rsp_id;

  int errs   = 0;
  int checks = 0;
  int model_last = NREQ - 1;

  always #5 clk = ~clk;

  shift_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_amt   (req_amt),
    .req_type  (req_type),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Reference shift, one bit position at a time.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int amt, input int t);
    logic [31:0] r = a;
    for (int k = 0; k < amt; k++) begin
      case (t)
        0:       r = r << 1;
        1:       r = r >> 1;
        2:       r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  // Winner among valid requesters, or -1 if none.
  function automatic int model_winner(input logic [NREQ-1:0] v, input int last);
`ifdef SHIFT_ARB_RR_EN
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
`else
    for (int c = 0; c < int'(NREQ); c++) begin
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic clr_reqs;
    req_valid = '0;
    req_a     = '0;
    req_amt   = '0;
    req_type  = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [4:0] amt,
                         input logic [1:0] t);
    req_valid[i]         = 1'b1;
    req_a[32*i +: 32]    = a;
    req_amt[5*i +: 5]    = amt;
    req_type[2*i +: 2]   = t;
  endtask

  // Leaves the bench at posedge+1 in the first cycle after reset release.
  task automatic do_reset;
    rst_n = 1'b0;
    clr_reqs();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  // One transaction from an idle block; observations only, checks by caller.
  // Operands are scrambled after accept to show they are not reused.
  task automatic issue(input int i, input logic [31:0] a, input logic [4:0] amt,
                       input logic [1:0] t, output logic [NREQ-1:0] rdy,
                       output logic v_exec, output logic v_resp,
                       output logic [31:0] d, output logic [IW-1:0] id);
    set_req(i, a, amt, t);
    @(negedge clk);
    rdy = req_ready;
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    req_a[32*i +: 32] = $urandom;
    req_amt[5*i +: 5] = 5'($urandom_range(0, 31));
    @(negedge clk);
    v_exec = rsp_valid;
    @(negedge clk);
    v_resp = rsp_valid;
    d      = rsp_data;
    id     = rsp_id;
    @(posedge clk);
    #1;
    if (model_winner(rdy, model_last) >= 0) model_last = i;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    clr_reqs();
    req_valid = '1;
    #1;
    checks++; if (req_ready !== '0) begin errs++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== '0) begin errs++; $display("FAIL reset_data: got %h want 0", rsp_data); end
    checks++; if (rsp_id !== '0) begin errs++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    // Asynchronous reset while a response is being held.
    do_reset();
    rsp_ready = 1'b0;
    set_req(3, 32'hCAFE_0001, 5'd4, ShSrl);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3)
      begin errs++; $display("FAIL reset_pre_resp: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id); end
    req_valid = '1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || req_ready !== '0)
      begin errs++; $display("FAIL reset_async_resp: got v=%b d=%h id=%0d rdy=%b want all 0",
                             rsp_valid, rsp_data, rsp_id, req_ready); end
    clr_reqs();
  endtask

  task automatic test_single;
    logic [NREQ-1:0] rdy; logic ve, vr; logic [31:0] d; logic [IW-1:0] id;
    do_reset();
    issue(0, 32'h0000_0F00, 5'd1, ShSll, rdy, ve, vr, d, id);
    checks++; if (rdy !== 4'b0001) begin errs++; $display("FAIL single_ready: got %b want 0001", rdy); end
    checks++; if (ve !== 1'b0) begin errs++; $display("FAIL single_exec_valid: got %b want 0", ve); end
    checks++; if (vr !== 1'b1) begin errs++; $display("FAIL single_resp_valid: got %b want 1", vr); end
    checks++; if (d !== 32'h0000_1E00) begin errs++; $display("FAIL single_data: got %h want 00001e00", d); end
    checks++; if (id !== 2'd0) begin errs++; $display("FAIL single_id: got %0d want 0", id); end
  endtask

  task automatic test_types;
    logic [31:0] ta[9];
    int          tm[9];
    int          tt[9];
    logic [31:0] te[9];
    logic [NREQ-1:0] rdy; logic ve, vr; logic [31:0] d; logic [IW-1:0] id;
    logic [31:0] ra; int rm, rt, ri;
    ta = '{32'h0000_0F00, 32'h0000_0F00, 32'h8000_0000, 32'h0000_0F00, 32'h0000_0F00,
           32'h8000_0000, 32'h0000_0F00, 32'h8000_0000, 32'h0000_0001};
    tm = '{5, 8, 8, 0, 0, 0, 0, 31, 31};
    tt = '{1, 3, 2, 0, 1, 2, 3, 2, 0};
    te = '{32'h0000_0078, 32'h0000_000F, 32'hFF80_0000, 32'h0000_0F00, 32'h0000_0F00,
           32'h8000_0000, 32'h0000_0F00, 32'hFFFF_FFFF, 32'h8000_0000};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      issue(k % NREQ, ta[k], 5'(tm[k]), 2'(tt[k]), rdy, ve, vr, d, id);
      checks++; if (vr !== 1'b1 || d !== te[k])
        begin errs++; $display("FAIL type_vec%0d: got v=%b d=%h want v=1 d=%h", k, vr, d, te[k]); end
      checks++; if (id !== IW'(k % NREQ))
        begin errs++; $display("FAIL type_vec%0d_id: got %0d want %0d", k, id, k % NREQ); end
    end
    for (int k = 0; k < 24; k++) begin
      ra = $urandom; rm = $urandom_range(0, 31); rt = $urandom_range(0, 3);
      ri = $urandom_range(0, NREQ - 1);
      issue(ri, ra, 5'(rm), 2'(rt), rdy, ve, vr, d, id);
      checks++; if (vr !== 1'b1 || d !== ref_shift(ra, rm, rt) || id !== IW'(ri))
        begin errs++; $display("FAIL type_rand%0d: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                               k, vr, d, id, ref_shift(ra, rm, rt), ri); end
    end
  endtask

  task automatic test_contention;
    int exp_ord[5];
    int got[$];
    int g;
    logic [31:0] expd[NREQ];
`ifdef SHIFT_ARB_RR_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) begin
      set_req(i, 32'h0000_0100 * (i + 1) + i, 5'(i + 1), 2'(i));
      expd[i] = ref_shift(32'h0000_0100 * (i + 1) + i, i + 1, i);
    end
    g = 0;
    for (int c = 0; c < 20 && g < 5; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && got.size() > 0) begin
        checks++; if (rsp_id !== IW'(got[0]) || rsp_data !== expd[got[0]])
          begin errs++; $display("FAIL contention_rsp: got id=%0d d=%h want id=%0d d=%h",
                                 rsp_id, rsp_data, got[0], expd[got[0]]); end
        void'(got.pop_front());
      end
      if (req_ready !== '0) begin
        checks++; if (req_ready !== (NREQ'(1) << exp_ord[g]))
          begin errs++; $display("FAIL contention_grant%0d: got %b want %b", g, req_ready,
                                 NREQ'(1) << exp_ord[g]); end
        got.push_back(exp_ord[g]);
        model_last = exp_ord[g];
        g++;
      end
    end
    checks++; if (g != 5) begin errs++; $display("FAIL contention_timeout: got %0d grants want 5", g); end
    clr_reqs();
  endtask

  task automatic test_backpressure;
    do_reset();
    rsp_ready = 1'b0;
    set_req(2, 32'h1234_5678, 5'd12, ShRor);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    set_req(1, 32'h0000_00FF, 5'd4, ShSll);
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errs++; $display("FAIL bp_exec_ready: got %b want 0", req_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h6781_2345 || rsp_id !== 2'd2 || req_ready !== '0)
        begin errs++; $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d rdy=%b want v=1 d=67812345 id=2 rdy=0",
                               c, rsp_valid, rsp_data, rsp_id, req_ready); end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== '0 || rsp_valid !== 1'b1)
      begin errs++; $display("FAIL bp_release: got rdy=%b v=%b want rdy=0 v=1", req_ready, rsp_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h0000_0FF0)
      begin errs++; $display("FAIL bp_second: got v=%b id=%0d d=%h want v=1 id=1 d=00000ff0",
                             rsp_valid, rsp_id, rsp_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop;
    logic [NREQ-1:0] rdy; logic ve, vr; logic [31:0] d; logic [IW-1:0] id;
    do_reset();
    issue(3, 32'hDEAD_BEEF, 5'd4, ShSrl, rdy, ve, vr, d, id);
    checks++; if (d !== 32'h0DEA_DBEE || id !== 2'd3)
      begin errs++; $display("FAIL midop_first: got d=%h id=%0d want d=0deadbee id=3", d, id); end
    set_req(0, 32'h0F0F_0000, 5'd3, ShSll);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0)
      begin errs++; $display("FAIL midop_async: got v=%b d=%h id=%0d want all 0", rsp_valid, rsp_data, rsp_id); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_last = NREQ - 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL midop_stale%0d: got v=%b want 0", c, rsp_valid); end
    end
    @(posedge clk);
    #1;
    issue(2, 32'h0000_0F00, 5'd8, ShRor, rdy, ve, vr, d, id);
    checks++; if (rdy !== 4'b0100 || vr !== 1'b1 || d !== 32'h0000_000F || id !== 2'd2)
      begin errs++; $display("FAIL midop_new: got rdy=%b v=%b d=%h id=%0d want rdy=0100 v=1 d=0000000f id=2",
                             rdy, vr, d, id); end
  endtask

  task automatic test_withdraw;
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 32'hA5A5_0000, 5'd2, ShSrl);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL wd_grant0: got %b want 0001", req_ready); end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    #1 set_req(1, 32'h1111_1111, 5'd1, ShSll);
    @(negedge clk);
    checks++; if (req_ready !== '0 || rsp_valid !== 1'b1 || rsp_id !== 2'd0)
      begin errs++; $display("FAIL wd_in_resp: got rdy=%b v=%b id=%0d want rdy=0 v=1 id=0",
                             req_ready, rsp_valid, rsp_id); end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== '0 || (rsp_valid === 1'b1 && rsp_id === 2'd1))
        begin errs++; $display("FAIL wd_cycle%0d: got rdy=%b v=%b id=%0d want rdy=0 and no id 1",
                               c, req_ready, rsp_valid, rsp_id); end
    end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h2969_4000 || rsp_id !== 2'd0)
      begin errs++; $display("FAIL wd_final: got v=%b d=%h id=%0d want v=0 d=29694000 id=0",
                             rsp_valid, rsp_data, rsp_id); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    bit          has_out;
    int          out_id, out_cyc, granted, w;
    logic [31:0] out_data;
    logic [NREQ-1:0] exp_rdy;
    bit          exp_v;
    do_reset();
    has_out = 0; granted = -1; out_id = 0; out_cyc = 0; out_data = '0;
    for (int n = 0; n < 400; n++) begin
      if (granted >= 0) begin
        req_valid[granted] = 1'b0;
        req_a[32*granted +: 32] = $urandom;
      end
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      granted = -1;
      @(negedge clk);
      exp_v   = has_out && (n >= out_cyc + 2);
      w       = has_out ? -1 : model_winner(req_valid, model_last);
      exp_rdy = (w >= 0) ? (NREQ'(1) << w) : '0;
      checks++; if (req_ready !== exp_rdy)
        begin errs++; $display("FAIL rand_ready@%0d: got %b want %b", n, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_v)
        begin errs++; $display("FAIL rand_valid@%0d: got %b want %b", n, rsp_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rsp_data !== out_data || rsp_id !== IW'(out_id))
          begin errs++; $display("FAIL rand_rsp@%0d: got d=%h id=%0d want d=%h id=%0d",
                                 n, rsp_data, rsp_id, out_data, out_id); end
        if (rsp_ready) has_out = 0;
      end
      if (w >= 0) begin
        has_out  = 1;
        out_id   = w;
        out_data = ref_shift(req_a[32*w +: 32], int'(req_amt[5*w +: 5]), int'(req_type[2*w +: 2]));
        out_cyc  = n;
        model_last = w;
        granted  = w;
      end
      @(posedge clk);
      #1;
    end
    clr_reqs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr_reqs();
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_types();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (legal 2..8); IW = $clog2(NREQ) is derived.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: req_valid  input  NREQ  per-requester request strobe.
REQ-005 SHALL have port: req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-006 SHALL have port: req_a  input  32*NREQ  operand, requester i in bits [32i+31:32i].
REQ-007 SHALL have port: req_amt  input  5*NREQ  shift amount, requester i in bits [5i+4:5i].
REQ-008 SHALL have port: req_type  input  2*NREQ  shift type, requester i in bits [2i+1:2i]: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-009 SHALL have port: rsp_valid  output  1  result available.
REQ-010 SHALL have port: rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: rsp_data  output  32  shifted result.
REQ-012 SHALL have port: rsp_id  output  IW  index of the requester that owns rsp_data.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; no other states.
REQ-014 IDLE: if any req_valid, SHALL pick one winner, assert its req_ready combinationally in that cycle, latch its a/amt/type/index, and go to EXEC; otherwise stay in IDLE.
REQ-015 req_ready SHALL be all-zero in EXEC and RESP.
REQ-016 EXEC: SHALL apply the latched operands to the shared shifter for one cycle, register the result into rsp_data and the index into rsp_id, and go to RESP.
REQ-017 RESP: SHALL hold rsp_valid=1 with stable rsp_data/rsp_id until rsp_ready=1, then go to IDLE in the next cycle.
REQ-018 Latency: request accepted at edge N SHALL give rsp_valid=1 after edge N+2; minimum issue interval is 3 cycles.
REQ-019 Shift semantics: SLL/SRL fill with zeros; SRA fills with a[31]; ROR rotates right; amt=0 SHALL return a unchanged for all types.
REQ-020 Requesters SHALL hold req_valid and operands stable until their req_ready is seen; the block SHALL NOT depend on operands after the accept cycle.
REQ-021 A requester that deasserts req_valid before it is granted SHALL lose its turn without error.
REQ-022 rsp_data and rsp_id SHALL hold their last value outside RESP; only rsp_valid qualifies them.

Reset
REQ-023 rst_n=0 SHALL force IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, and RR pointer = NREQ-1, all without waiting for a clock edge.
REQ-024 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced after reset release.
REQ-025 Requests in the first cycle after reset release SHALL be arbitrated normally.

Configuration
REQ-026 Macro SHIFT_ARB_RR_EN defined: round-robin arbitration; search starts at (last granted + 1) mod NREQ; pointer updates only on grant.
REQ-027 SHIFT_ARB_RR_EN undefined: fixed priority, lowest index wins; pointer logic is removed.

Structure
REQ-028 Package shift_arb_pkg SHALL hold the shift-type encodings (SLL/SRL/SRA/ROR) and the FSM state encoding.
REQ-029 The shifter datapath SHALL be the existing shifter_32 instantiated once as the only sub-module; arbitration and FSM stay in shift_arbiter.

Verification
REQ-030 Single request: req0 a=0x00000F00, amt=1, type=SLL -> req_ready[0] in accept cycle; rsp_valid two edges later; rsp_data=0x00001E00, rsp_id=0.
REQ-031 Type coverage, a=0x00000F00: SRL amt=5 -> 0x00000078; ROR amt=8 -> 0x0000000F; SRA of 0x80000000 amt=8 -> 0xFF800000; any type amt=0 -> a.
REQ-032 Contention, RR build: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; fixed build -> 0,0,0,...
REQ-033 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0; after rsp_ready=1 next grant occurs one cycle later.
REQ-034 Reset mid-op: rst_n low during EXEC -> rsp_valid=0 immediately; after release no stale response; new req2 completes with rsp_id=2.
REQ-035 Withdrawal: req1 valid 1 cycle while block is in RESP, then dropped -> req1 never granted and no response with rsp_id=1.
